// File: rtl/btn_pulse_gen_pkg.sv
// Shared constants for the button front end and the speed/pause controller.
// Holds the channel bit assignments, the system clock rate and the default
// debounce window derived from it.
package btn_pkg;

  // Bit position of each button within btn_raw / btn_level / btn_pulse
  localparam int BTN_SPEED_U = 0;
  localparam int BTN_SPEED_D = 1;
  localparam int BTN_PAUSE   = 2;

  localparam int N_BTN_DEFAULT = 3;

  // System clock shared with the speed controller
  localparam int CLK_FREQ_HZ = 10_000_000;

  // 20 ms of stable input before a level is accepted
  localparam int DEBOUNCE_MS       = 20;
  localparam int DB_CYCLES_DEFAULT = (CLK_FREQ_HZ / 1000) * DEBOUNCE_MS;

  // Counter width able to hold db_cycles-1; never narrower than one bit
  function automatic int db_cnt_width(input int db_cycles);
    return (db_cycles < 2) ? 1 : $clog2(db_cycles);
  endfunction

endpackage

// File: rtl/btn_pulse_gen_if.sv
// Button bundle between the board pins and the speed/pause controller.
// The master side drives the raw pins; the slave side (the conditioner)
// returns the debounced levels and one-cycle press pulses.
interface btn_pulse_gen_if #(
  parameter int N_BTN = 3
);

  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_pulse;

  modport master (
    output btn_raw,
    input  btn_level,
    input  btn_pulse
  );

  modport slave (
    input  btn_raw,
    output btn_level,
    output btn_pulse
  );

endinterface

// File: rtl/btn_pulse_gen_debounce_ch.sv
// One button channel: two-flop synchronizer, debounce counter with the
// accepted (stable) level, and a registered press pulse that fires on the
// same edge the stable level goes 0->1.
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic level,
  output logic raw_pulse
);

  localparam int                 CNT_W   = db_cnt_width(DB_CYCLES);
  localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE = CNT_W'(1);

  logic             s1;
  logic             s2;
  logic             stable;
  logic [CNT_W-1:0] cnt;

  // Bring the asynchronous pin into the clk domain; only s2 is used later
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= btn_raw;
      s2 <= s1;
    end
  end

  // Accept a new level only after it has differed from stable for the full window
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      stable    <= 1'b0;
      raw_pulse <= 1'b0;
    end else begin
      raw_pulse <= 1'b0;
      if (s2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        stable    <= s2;
        cnt       <= '0;
        raw_pulse <= s2;
      end else begin
        cnt <= cnt + CNT_ONE;
      end
    end
  end

  assign level = stable;

endmodule

// File: rtl/btn_pulse_gen.sv
// Button conditioner feeding the speed/pause controller. Each channel is
// synchronized, debounced and edge-detected independently; the top only
// applies the optional lowest-index-wins mask to the press pulses.
module btn_pulse_gen
  import btn_pkg::*;
#(
  parameter int N_BTN       = N_BTN_DEFAULT,
  parameter int DB_CYCLES   = DB_CYCLES_DEFAULT,
  parameter bit PRIORITY_EN = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  btn_pulse_gen_if.slave         bus
);

  localparam logic [N_BTN-1:0] ONE = N_BTN'(1);

  logic [N_BTN-1:0] raw_pulse;
  logic [N_BTN-1:0] stable_level;
  logic [N_BTN-1:0] pulse_out;

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_debounce_ch #(
      .DB_CYCLES (DB_CYCLES)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .btn_raw   (bus.btn_raw[i]),
      .level     (stable_level[i]),
      .raw_pulse (raw_pulse[i])
    );
  end

  if (PRIORITY_EN) begin : g_prio
    // Keep only the lowest set bit; the other simultaneous presses are dropped
    always_comb begin
      pulse_out = raw_pulse & (~raw_pulse + ONE);
    end
  end else begin : g_noprio
    // Channels are independent, every press pulse passes straight through
    always_comb begin
      pulse_out = raw_pulse;
    end
  end

  assign bus.btn_level = stable_level;
  assign bus.btn_pulse = pulse_out;

endmodule

// File: tb/tb_btn_pulse_gen.sv
// Bench for btn_pulse_gen: two short-window instances (with and without
// priority masking) share the same raw stimulus, a third instance uses a
// long non-power-of-two window. Expected press pulses are queued with the
// edge they must appear on and matched when a pulse is seen.
module tb_btn_pulse_gen;

  localparam int DB     = 4;
  localparam int BIG_DB = 5000;
  localparam int N_VEC  = 15;

  typedef struct {
    int         dut;
    logic [2:0] pulse;
    int         edge_no;
  } exp_t;

  typedef struct {
    logic [2:0] raw;
    int         hold;
    logic [2:0] exp_p0;
    logic [2:0] exp_p1;
    logic [2:0] exp_level;
  } vec_t;

  logic clk;
  logic rst;
  int   edge_cnt = 0;
  int   checks   = 0;
  int   errors   = 0;
  exp_t exp_q[$];
  vec_t vecs[N_VEC];

  btn_pulse_gen_if #(.N_BTN(3)) if_p0 ();
  btn_pulse_gen_if #(.N_BTN(3)) if_p1 ();
  btn_pulse_gen_if #(.N_BTN(3)) if_big ();

  btn_pulse_gen #(.N_BTN(3), .DB_CYCLES(DB), .PRIORITY_EN(1'b0)) dut_p0 (
    .clk (clk),
    .rst (rst),
    .bus (if_p0)
  );

  btn_pulse_gen #(.N_BTN(3), .DB_CYCLES(DB), .PRIORITY_EN(1'b1)) dut_p1 (
    .clk (clk),
    .rst (rst),
    .bus (if_p1)
  );

  btn_pulse_gen #(.N_BTN(3), .DB_CYCLES(BIG_DB), .PRIORITY_EN(1'b0)) dut_big (
    .clk (clk),
    .rst (rst),
    .bus (if_big)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Index of the most recent rising clk edge
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic pushExpected(input int dut, input logic [2:0] pulse, input int edge_no);
    exp_t e;
    e.dut     = dut;
    e.pulse   = pulse;
    e.edge_no = edge_no;
    exp_q.push_back(e);
  endtask

  task automatic checkOutput(input string name, input logic [2:0] got, input logic [2:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %b, expected %b", name, got, exp);
    end
  endtask

  task automatic checkPulse(input int dut, input logic [2:0] got);
    int idx;
    idx = -1;
    if (got === 3'b000) return;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (idx < 0 && exp_q[i].dut == dut) idx = i;
    end
    checks++;
    if (idx < 0) begin
      errors++;
      $display("[TB] FAIL pulse_dut%0d: got %b at edge %0d, expected no pulse", dut, got, edge_cnt);
    end else begin
      if (exp_q[idx].pulse !== got || exp_q[idx].edge_no != edge_cnt) begin
        errors++;
        $display("[TB] FAIL pulse_dut%0d: got %b at edge %0d, expected %b at edge %0d",
                 dut, got, edge_cnt, exp_q[idx].pulse, exp_q[idx].edge_no);
      end
      exp_q.delete(idx);
    end
  endtask

  // Advance one clk edge, watching all pulse outputs mid-cycle
  task automatic tick();
    @(negedge clk);
    checkPulse(0, if_p0.btn_pulse);
    checkPulse(1, if_p1.btn_pulse);
    checkPulse(2, if_big.btn_pulse);
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [2:0] raw, input int hold,
                               input logic [2:0] exp_p0, input logic [2:0] exp_p1);
    int first_edge;
    first_edge    = edge_cnt + 1;
    if_p0.btn_raw = raw;
    if_p1.btn_raw = raw;
    if (exp_p0 != 3'b000) pushExpected(0, exp_p0, first_edge + DB + 1);
    if (exp_p1 != 3'b000) pushExpected(1, exp_p1, first_edge + DB + 1);
    repeat (hold) tick();
  endtask

  task automatic applyBig(input logic [2:0] raw, input int hold, input logic [2:0] exp_pulse);
    int first_edge;
    first_edge     = edge_cnt + 1;
    if_big.btn_raw = raw;
    if (exp_pulse != 3'b000) pushExpected(2, exp_pulse, first_edge + BIG_DB + 1);
    repeat (hold) tick();
  endtask

  initial begin
    int e0;

    // raw, hold, pulse (no priority), pulse (priority), level at end
    vecs[0]  = '{3'b000,  3, 3'b000, 3'b000, 3'b000};
    vecs[1]  = '{3'b001, 20, 3'b001, 3'b001, 3'b001};
    vecs[2]  = '{3'b000, 10, 3'b000, 3'b000, 3'b000};
    vecs[3]  = '{3'b010,  2, 3'b000, 3'b000, 3'b000};
    vecs[4]  = '{3'b000,  2, 3'b000, 3'b000, 3'b000};
    vecs[5]  = '{3'b010,  2, 3'b000, 3'b000, 3'b000};
    vecs[6]  = '{3'b000,  2, 3'b000, 3'b000, 3'b000};
    vecs[7]  = '{3'b010, 20, 3'b010, 3'b010, 3'b010};
    vecs[8]  = '{3'b000, 10, 3'b000, 3'b000, 3'b000};
    vecs[9]  = '{3'b100,  3, 3'b000, 3'b000, 3'b000};
    vecs[10] = '{3'b000, 10, 3'b000, 3'b000, 3'b000};
    vecs[11] = '{3'b111, 10, 3'b111, 3'b001, 3'b111};
    vecs[12] = '{3'b000, 10, 3'b000, 3'b000, 3'b000};
    vecs[13] = '{3'b100, 10, 3'b100, 3'b100, 3'b100};
    vecs[14] = '{3'b000, 10, 3'b000, 3'b000, 3'b000};

    rst            = 1'b1;
    if_p0.btn_raw  = 3'b000;
    if_p1.btn_raw  = 3'b000;
    if_big.btn_raw = 3'b000;
    @(posedge clk);
    #1;
    repeat (2) tick();
    checkOutput("reset_level_p0", if_p0.btn_level, 3'b000);
    checkOutput("reset_pulse_p0", if_p0.btn_pulse, 3'b000);
    checkOutput("reset_level_p1", if_p1.btn_level, 3'b000);
    checkOutput("reset_level_big", if_big.btn_level, 3'b000);
    rst = 1'b0;

    for (int i = 0; i < N_VEC; i++) begin
      applyStimulus(vecs[i].raw, vecs[i].hold, vecs[i].exp_p0, vecs[i].exp_p1);
      checkOutput($sformatf("vec%0d_level_p0", i), if_p0.btn_level, vecs[i].exp_level);
      checkOutput($sformatf("vec%0d_level_p1", i), if_p1.btn_level, vecs[i].exp_level);
    end

    $display("[TB] press/release level latency");
    if_p0.btn_raw = 3'b001;
    if_p1.btn_raw = 3'b001;
    e0 = edge_cnt + 1;
    pushExpected(0, 3'b001, e0 + DB + 1);
    pushExpected(1, 3'b001, e0 + DB + 1);
    repeat (DB + 1) tick();
    checkOutput("press_lat_before", if_p0.btn_level, 3'b000);
    tick();
    checkOutput("press_lat_at", if_p0.btn_level, 3'b001);
    repeat (5) tick();
    if_p0.btn_raw = 3'b000;
    if_p1.btn_raw = 3'b000;
    repeat (DB + 1) tick();
    checkOutput("release_lat_before", if_p0.btn_level, 3'b001);
    tick();
    checkOutput("release_lat_at", if_p0.btn_level, 3'b000);
    repeat (4) tick();

    $display("[TB] reset in the middle of a debounce count");
    applyStimulus(3'b001, 4, 3'b000, 3'b000);
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checkOutput("rst_level_p0", if_p0.btn_level, 3'b000);
      checkOutput("rst_pulse_p0", if_p0.btn_pulse, 3'b000);
      checkOutput("rst_pulse_p1", if_p1.btn_pulse, 3'b000);
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    applyStimulus(3'b001, 12, 3'b001, 3'b001);
    checkOutput("after_rst_level_p0", if_p0.btn_level, 3'b001);
    applyStimulus(3'b000, 10, 3'b000, 3'b000);
    checkOutput("after_rst_release_p0", if_p0.btn_level, 3'b000);

    $display("[TB] long debounce window");
    applyBig(3'b001, 6250, 3'b001);
    checkOutput("big_press_level", if_big.btn_level, 3'b001);
    applyBig(3'b000, 5100, 3'b000);
    checkOutput("big_release_level", if_big.btn_level, 3'b000);
    applyBig(3'b001, 3750, 3'b000);
    checkOutput("big_short_level", if_big.btn_level, 3'b000);
    applyBig(3'b000, 100, 3'b000);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL pending_pulses: got %0d never seen, expected 0", exp_q.size());
      foreach (exp_q[i])
        $display("[TB]   missing pulse dut%0d %b at edge %0d", exp_q[i].dut, exp_q[i].pulse, exp_q[i].edge_no);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
